// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and the shared nibble-to-segment decode.
// Segments are active-low, bit0=a .. bit6=g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Nibbles 10..15 show blank unless hex glyphs are enabled.
    function automatic logic [6:0] seg7_glyph_f(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    seg = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    seg = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    seg = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    seg = hex_mode ? SEG_E : SEG_BLANK;
            default: seg = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low segment decode.
module seg7_glyph
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    localparam logic HEX_EN = (HEX_MODE != 0);

    always_comb begin
        seg_o = seg7_glyph_f(nibble_i, HEX_EN);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking is compiled in when LZ_BLANK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int HEX_MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    output logic                  pending_o,
    output logic                  frame_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o
);

    localparam int TICK_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  frame_q, frame_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  tick_wrap;
    logic                  frame_wrap;
    logic                  lz_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph_seg;

    assign cur_nib = disp_val_q[idx_q*4 +: 4];

    seg7_glyph #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .nibble_i (cur_nib),
        .seg_o    (glyph_seg)
    );

    always_comb begin
        tick_wrap  = (tick_q == TICK_LAST);
        frame_wrap = tick_wrap && (idx_q == IDX_LAST);

        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
        idx_d  = idx_q;
        if (tick_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;

        // A load landing on the wrap itself bypasses the buffer so it is not lost.
        if (frame_wrap) begin
            if (load_i) begin
                disp_val_d = value_i;
                disp_dp_d  = dp_i;
            end else if (pend_vld_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end
        if (load_i) begin
            pend_val_d = value_i;
            pend_dp_d  = dp_i;
            if (!frame_wrap) begin
                pend_vld_d = 1'b1;
            end
        end

        lz_blank = 1'b0;
`ifdef LZ_BLANK_EN
        lz_blank = (idx_q != '0);
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= int'(idx_q) && (disp_val_q[k*4 +: 4] != 4'h0 || disp_dp_q[k])) begin
                lz_blank = 1'b0;
            end
        end
`endif

        frame_d = frame_wrap;
        // Slot start is dark so the previous digit's segments never ghost onto the next anode.
        if (tick_q == '0) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d        = '1;
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank ? SEG_BLANK : glyph_seg;
            dp_d        = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q     <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign pending_o = pend_vld_q;
    assign frame_o   = frame_q;
    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign an_o      = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: BCD and hex instances side by side, table vectors,
// hand sequences for buffering corners, and a random phase against a frame-level model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int C  = 4;
    localparam int FR = N * C;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpin;

    logic       pend_b, frame_b, dp_b, pend_h, frame_h, dp_h;
    logic [6:0] seg_b, seg_h;
    logic [3:0] an_b, an_h;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.N_DIGITS(N), .CLKS_PER_DIGIT(C), .HEX_MODE(0)) dut_bcd (
        .clk(clk), .reset_n(reset_n), .load_i(load), .value_i(value), .dp_i(dpin),
        .pending_o(pend_b), .frame_o(frame_b), .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b)
    );

    seg7_scan_driver #(.N_DIGITS(N), .CLKS_PER_DIGIT(C), .HEX_MODE(1)) dut_hex (
        .clk(clk), .reset_n(reset_n), .load_i(load), .value_i(value), .dp_i(dpin),
        .pending_o(pend_h), .frame_o(frame_h), .seg_o(seg_h), .dp_o(dp_h), .an_o(an_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [6:0] DEC_G [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] HEX_G [6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] glyph(input int n, input bit hex);
        if (n < 10) return DEC_G[n];
        if (hex) return HEX_G[n-10];
        return 7'h7F;
    endfunction

    function automatic logic [6:0] m_seg(input int cyc, input logic [15:0] val,
                                         input logic [3:0] dpv, input bit hex);
        int slot = cyc / C;
        int t    = cyc % C;
        if (t == 0) return 7'h7F;
`ifdef LZ_BLANK_EN
        if (slot > 0 && (val >> (4*slot)) == 16'h0 && (dpv >> slot) == 4'h0) return 7'h7F;
`endif
        return glyph(int'(val[4*slot +: 4]), hex);
    endfunction

    function automatic logic [3:0] m_an(input int cyc);
        if (cyc % C == 0) return 4'hF;
        return ~(4'b0001 << (cyc / C));
    endfunction

    function automatic logic m_dp(input int cyc, input logic [3:0] dpv);
        if (cyc % C == 0) return 1'b1;
        return ~dpv[cyc / C];
    endfunction

    int          m_cyc;
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dpv, m_pdp;
    logic        m_pvld;
    logic [6:0]  e_seg, e_seg_h;
    logic [3:0]  e_an;
    logic        e_dp, e_frame;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc   <= 0;
            m_val   <= '0;
            m_dpv   <= '0;
            m_pval  <= '0;
            m_pdp   <= '0;
            m_pvld  <= 1'b0;
            e_seg   <= 7'h7F;
            e_seg_h <= 7'h7F;
            e_an    <= 4'hF;
            e_dp    <= 1'b1;
            e_frame <= 1'b0;
        end else begin
            e_frame <= (m_cyc == FR - 1);
            e_seg   <= m_seg(m_cyc, m_val, m_dpv, 1'b0);
            e_seg_h <= m_seg(m_cyc, m_val, m_dpv, 1'b1);
            e_an    <= m_an(m_cyc);
            e_dp    <= m_dp(m_cyc, m_dpv);
            m_cyc   <= (m_cyc + 1) % FR;
            if (m_cyc == FR - 1) begin
                if (load) begin
                    m_val <= value;
                    m_dpv <= dpin;
                end else if (m_pvld) begin
                    m_val <= m_pval;
                    m_dpv <= m_pdp;
                end
                m_pvld <= 1'b0;
            end
            if (load) begin
                m_pval <= value;
                m_pdp  <= dpin;
                if (m_cyc != FR - 1) m_pvld <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("seg_bcd", 32'(seg_b), 32'(e_seg));
            check("seg_hex", 32'(seg_h), 32'(e_seg_h));
            check("an_bcd", 32'(an_b), 32'(e_an));
            check("an_hex", 32'(an_h), 32'(e_an));
            check("dp_bcd", 32'(dp_b), 32'(e_dp));
            check("dp_hex", 32'(dp_h), 32'(e_dp));
            check("frame", 32'({frame_b, frame_h}), 32'({e_frame, e_frame}));
            check("pending", 32'({pend_b, pend_h}), 32'({m_pvld, m_pvld}));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [27:0] sb;   // expected BCD segs {d3,d2,d1,d0}
        logic [27:0] sh;   // expected hex segs {d3,d2,d1,d0}
        logic [3:0]  dpo;  // expected dp_o per digit
    } vec_t;

    localparam logic [3:0] AN_SEQ [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    vec_t tbl [6];
    vec_t v_zero;

    task automatic load_word(input logic [15:0] val, input logic [3:0] d);
        load  = 1'b1;
        value = val;
        dpin  = d;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        int guard = 0;
        while (!frame_b && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_frame_seen"}, 32'(frame_b), 32'd1);
        for (int i = 0; i < 16; i++) begin
            int slot;
            int t;
            @(negedge clk);
            slot = i / 4;
            t    = i % 4;
            check({tag, "_an"}, 32'(an_b), (t == 0) ? 32'hF : 32'(AN_SEQ[slot]));
            check({tag, "_seg_bcd"}, 32'(seg_b), (t == 0) ? 32'h7F : 32'(v.sb[7*slot +: 7]));
            check({tag, "_seg_hex"}, 32'(seg_h), (t == 0) ? 32'h7F : 32'(v.sh[7*slot +: 7]));
            check({tag, "_dp"}, 32'(dp_b), (t == 0) ? 32'd1 : 32'(v.dpo[slot]));
        end
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        tbl[1] = '{16'h6789, 4'b0100, {7'h02, 7'h78, 7'h00, 7'h10}, {7'h02, 7'h78, 7'h00, 7'h10}, 4'b1011};
        tbl[2] = '{16'hB05A, 4'b0001, {7'h7F, 7'h40, 7'h12, 7'h7F}, {7'h03, 7'h40, 7'h12, 7'h08}, 4'b1110};
        tbl[3] = '{16'hFEDC, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0111};
`ifdef LZ_BLANK_EN
        tbl[4] = '{16'h0042, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111};
        tbl[5] = '{16'h0000, 4'b0010, {7'h7F, 7'h7F, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40, 7'h40}, 4'b1101};
        v_zero = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
`else
        tbl[4] = '{16'h0042, 4'b0000, {7'h40, 7'h40, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1111};
        tbl[5] = '{16'h0000, 4'b0010, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1101};
        v_zero = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
`endif

        reset_n = 1'b0;
        load    = 1'b0;
        value   = '0;
        dpin    = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'({seg_b, seg_h}), 32'({7'h7F, 7'h7F}));
        check("rst_an", 32'(an_b), 32'hF);
        check("rst_dp", 32'(dp_b), 32'd1);
        check("rst_frame", 32'(frame_b), 32'd0);
        check("rst_pending", 32'(pend_b), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load_word(tbl[i].value, tbl[i].dp);
            check_frame(tbl[i], $sformatf("vec%0d", i));
        end

        // Double buffer: two loads inside one frame, latest wins at the wrap.
        begin
            int guard = 0;
            while (an_b != 4'hD && guard < 32) begin
                @(negedge clk);
                guard++;
            end
            check("dbuf_reach_digit1", 32'(an_b), 32'hD);
            load_word(16'h5555, 4'b0000);
            check("dbuf_pending", 32'(pend_b), 32'd1);
            check("dbuf_unchanged", 32'(seg_b), 32'h40);
            load_word(tbl[1].value, tbl[1].dp);
            check("dbuf_pending2", 32'(pend_b), 32'd1);
            check_frame(tbl[1], "dbuf");
        end

        // Wrap collision: check_frame leaves us on a frame_o cycle; the next wrap is 15 cycles on.
        repeat (15) @(negedge clk);
        load_word(tbl[4].value, tbl[4].dp);
        check("coll_frame", 32'(frame_b), 32'd1);
        check("coll_pending", 32'(pend_b), 32'd0);
        check_frame(tbl[4], "coll");

        // Asynchronous reset mid-frame with a value still pending.
        load_word(16'h9999, 4'b1111);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_seg", 32'({seg_b, seg_h}), 32'({7'h7F, 7'h7F}));
        check("arst_an", 32'(an_b), 32'hF);
        check("arst_dp", 32'(dp_b), 32'd1);
        check("arst_frame", 32'(frame_b), 32'd0);
        check("arst_pending", 32'(pend_b), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_frame(v_zero, "arst_nosurvive");

        // Random loads checked every cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            load  = ($urandom_range(0, 6) == 0);
            value = 16'($urandom);
            dpin  = 4'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        repeat (2 * FR) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
